wb_arbiter: RTL and testbench
=============================

Name: wb_arbiter

Overview:
- Writeback stage directly upstream of the 64-entry register file (x0–x31 at 0–31, f0–f31 at 32–63).
- Merges two result producers into the regfile's single write port:
  - the single-cycle ALU path;
  - the long-latency path (mul/div/FPU), buffered in a small FIFO.
- Drives write_enable/write_addr/write_data from registers, one write per cycle at most.
- Includes a starvation guard so the long-latency path always drains.

Parameters:
- DEPTH, 4, long-path FIFO entries; power of two, >= 2.
- STARVE_LIMIT, 8, consecutive non-draining cycles with FIFO non-empty before the ALU is held off.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  reset, asynchronous, active-high.
- alu_valid  input  1  ALU result present this cycle.
- alu_ready  output  1  ALU result accepted when alu_valid && alu_ready.
- alu_addr  input  6  destination register index.
- alu_data  input  64  result value.
- long_valid  input  1  long-latency result present.
- long_ready  output  1  FIFO can accept; push when long_valid && long_ready.
- long_addr  input  6  destination register index.
- long_data  input  64  result value.
- write_enable  output  1  to regfile write_enable.
- write_addr  output  6  to regfile write_addr.
- write_data  output  64  to regfile write_data.
- fifo_count  output  clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (async, immediate on rst high):
  - write_enable=0, write_addr=0, write_data=0.
  - FIFO emptied (pointers and count 0), starve_cnt=0.
  - Therefore long_ready=1, alu_ready=1, fifo_count=0 while in reset and after it.
  - Reset mid-operation discards all buffered and in-flight results; no write is issued for them.
- Combinational control each cycle:
  - starve = (starve_cnt == STARVE_LIMIT).
  - alu_ready = !starve.
  - long_ready = (count != DEPTH). A pop in the same cycle does not free a slot for the push.
- Selection, evaluated in priority order:
  1. alu_valid && alu_ready: select the ALU result.
  2. FIFO non-empty: pop the head entry and select it.
  3. Otherwise idle.
- Output register at each posedge:
  - Selected source: write_addr/write_data load the selected addr/data; write_enable = (addr != 0).
  - Addr 0 is consumed (popped/accepted) but produces no write.
  - Idle: write_enable=0; write_addr/write_data hold their previous values.
- Latency:
  - ALU result accepted at edge N appears on the write port after edge N; the regfile commits it at edge N+1.
  - Long result pushed at edge N is at the earliest popped/registered at edge N+1. There is no same-cycle bypass through an empty FIFO.
- FIFO:
  - Circular buffer with a wrap-around pointer of clog2(DEPTH) bits; count increments on push, decrements on pop.
  - Simultaneous push and pop (only possible when not full) leaves count unchanged.
  - Entries are popped strictly in FIFO order.
- Starvation counter:
  - Cleared on any pop or when the FIFO is empty.
  - Otherwise increments each cycle the FIFO is non-empty and not popped, saturating at STARVE_LIMIT.
  - Once saturated, alu_ready drops; the next cycle pops, which clears the counter and restores alu_ready.
  - Result: the ALU loses at most one cycle per STARVE_LIMIT+1 cycles.
- Producer holds: the ALU producer must hold alu_valid/addr/data while alu_ready=0; the long producer likewise while long_ready=0.
- Ordering between the two paths to the same register is not enforced here; the issue scoreboard guarantees it.

Test Plan:
- Reset then idle: rst pulse mid-cycle -> all outputs 0 asynchronously; alu_ready=1, long_ready=1, fifo_count=0; write_enable stays 0 with no valids.
- ALU path: alu_valid=1, addr=5, data=0xDEADBEEF at edge N -> after N write_enable=1, write_addr=5, write_data=0xDEADBEEF; next idle cycle write_enable=0, addr/data held.
- Addr-0 drop: ALU addr=0, data=0x1234 -> accepted (alu_ready=1), write_enable=0. Long push with addr=0 -> popped, fifo_count returns to 0, no write.
- FIFO full and order: push long addrs 33,34,35,36 with alu_valid held 1 (STARVE_LIMIT=8):
  - after 4 pushes fifo_count=4 and long_ready=0;
  - after 8 non-draining cycles alu_ready=0 for one cycle and addr 33 is written;
  - then ALU resumes, and 34, 35, 36 drain in order.
- Push/pop same cycle: FIFO at count 2, alu_valid=0, long_valid=1 -> head popped and new entry pushed, fifo_count stays 2; the entry pushed into an empty FIFO is written one cycle later, not the same cycle.
- Reset mid-operation: FIFO holding 3 entries, rst asserted -> fifo_count=0, write_enable=0 immediately; after release no stale entries are written.

Source files
------------

// File: rtl/wb_arbiter.sv
// wb_arbiter: writeback arbiter in front of the 64-entry register file
// (x0-x31 at 0-31, f0-f31 at 32-63). Merges the single-cycle ALU result
// path and a FIFO-buffered long-latency path (mul/div/FPU) into the
// regfile's single registered write port.
//
// Ports:
//   clk, rst                    clock; asynchronous active-high reset
//   alu_valid/ready/addr/data   ALU result handshake (accept on valid&&ready)
//   long_valid/ready/addr/data  long-latency result handshake (push into FIFO)
//   write_enable/addr/data      registered regfile write port
//   fifo_count                  current long-path FIFO occupancy
//
// Selection priority: ALU first, then the FIFO head. A starvation counter
// holds off the ALU for one cycle after STARVE_LIMIT cycles in which the
// FIFO was non-empty but not drained. Destination 0 is consumed without
// issuing a write.
module wb_arbiter #(
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     alu_valid,
  output logic                     alu_ready,
  input  logic [5:0]               alu_addr,
  input  logic [63:0]              alu_data,
  input  logic                     long_valid,
  output logic                     long_ready,
  input  logic [5:0]               long_addr,
  input  logic [63:0]              long_data,
  output logic                     write_enable,
  output logic [5:0]               write_addr,
  output logic [63:0]              write_data,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

  localparam logic [CW-1:0] L_FULL  = CW'(DEPTH);
  localparam logic [SW-1:0] L_LIMIT = SW'(STARVE_LIMIT);

  logic [5:0]    r_addr_mem [DEPTH];
  logic [63:0]   r_data_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic [SW-1:0] r_starve_cnt;

  logic          w_starve;
  logic          w_empty;
  logic          w_alu_take;
  logic          w_push;
  logic          w_pop;
  logic          w_sel;
  logic [5:0]    w_sel_addr;
  logic [63:0]   w_sel_data;

  assign w_starve   = (r_starve_cnt == L_LIMIT);
  assign w_empty    = (r_count == '0);
  assign alu_ready  = !w_starve;
  // Full check uses the current count only: a pop this cycle does not
  // make room for a push in the same cycle.
  assign long_ready = (r_count != L_FULL);
  assign fifo_count = r_count;

  assign w_alu_take = alu_valid && alu_ready;
  assign w_push     = long_valid && long_ready;
  assign w_pop      = !w_alu_take && !w_empty;

  always_comb begin
    w_sel      = 1'b0;
    w_sel_addr = '0;
    w_sel_data = '0;
    if (w_alu_take) begin
      w_sel      = 1'b1;
      w_sel_addr = alu_addr;
      w_sel_data = alu_data;
    end else if (w_pop) begin
      w_sel      = 1'b1;
      w_sel_addr = r_addr_mem[r_rptr];
      w_sel_data = r_data_mem[r_rptr];
    end
  end

  // Storage needs no reset: validity is tracked entirely by r_count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_addr_mem[r_wptr] <= long_addr;
      r_data_mem[r_wptr] <= long_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_count      <= '0;
      r_starve_cnt <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);

      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase

      if (w_pop || w_empty)
        r_starve_cnt <= '0;
      else if (r_starve_cnt != L_LIMIT)
        r_starve_cnt <= r_starve_cnt + SW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      write_enable <= 1'b0;
      write_addr   <= '0;
      write_data   <= '0;
    end else if (w_sel) begin
      write_enable <= (w_sel_addr != '0);
      write_addr   <= w_sel_addr;
      write_data   <= w_sel_data;
    end else begin
      write_enable <= 1'b0;
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Testbench for wb_arbiter: directed scenarios plus randomized traffic,
// all checked against a queue-based reference model of the writeback rules.
module tb_wb_arbiter;

  localparam int unsigned DEPTH        = 4;
  localparam int unsigned STARVE_LIMIT = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        alu_valid = 1'b0;
  logic        alu_ready;
  logic [5:0]  alu_addr = '0;
  logic [63:0] alu_data = '0;
  logic        long_valid = 1'b0;
  logic        long_ready;
  logic [5:0]  long_addr = '0;
  logic [63:0] long_data = '0;
  logic        write_enable;
  logic [5:0]  write_addr;
  logic [63:0] write_data;
  logic [$clog2(DEPTH):0] fifo_count;

  wb_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_ready(alu_ready),
    .alu_addr(alu_addr), .alu_data(alu_data),
    .long_valid(long_valid), .long_ready(long_ready),
    .long_addr(long_addr), .long_data(long_data),
    .write_enable(write_enable), .write_addr(write_addr),
    .write_data(write_data), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: pending long results as a queue, a count of
  // consecutive undrained cycles, and the expected write-port contents.
  typedef struct {
    logic [5:0]  a;
    logic [63:0] d;
  } ent_t;

  ent_t        q[$];
  int          m_wait;
  logic        exp_we;
  logic [5:0]  exp_addr;
  logic [63:0] exp_data;
  bit          alu_taken, long_taken;

  task automatic model_clear();
    q.delete();
    m_wait   = 0;
    exp_we   = 1'b0;
    exp_addr = '0;
    exp_data = '0;
  endtask

  task automatic step(input logic av, input logic [5:0] aa, input logic [63:0] ad,
                      input logic lv, input logic [5:0] la, input logic [63:0] ld);
    bit   ar, lr, take, push, pop, was_empty;
    ent_t e;
    @(negedge clk);
    alu_valid = av;  alu_addr = aa;  alu_data = ad;
    long_valid = lv; long_addr = la; long_data = ld;
    #1;
    ar = (m_wait < STARVE_LIMIT);
    lr = (q.size() < DEPTH);
    check("alu_ready", 64'(alu_ready), 64'(ar));
    check("long_ready", 64'(long_ready), 64'(lr));
    check("fifo_count", 64'(fifo_count), 64'(q.size()));
    take      = av && ar;
    push      = lv && lr;
    was_empty = (q.size() == 0);
    pop       = !take && !was_empty;
    if (take) begin
      exp_we = (aa != 0); exp_addr = aa; exp_data = ad;
    end else if (pop) begin
      e = q.pop_front();
      exp_we = (e.a != 0); exp_addr = e.a; exp_data = e.d;
    end else begin
      exp_we = 1'b0;
    end
    if (pop || was_empty) m_wait = 0;
    else if (m_wait < STARVE_LIMIT) m_wait++;
    if (push) begin
      e.a = la; e.d = ld;
      q.push_back(e);
    end
    alu_taken  = take;
    long_taken = push;
    @(posedge clk);
    #1;
    check("write_enable", 64'(write_enable), 64'(exp_we));
    check("write_addr", 64'(write_addr), 64'(exp_addr));
    check("write_data", write_data, exp_data);
  endtask

  // Reset asserted mid-cycle; outputs must clear before any clock edge.
  task automatic do_reset();
    @(negedge clk);
    alu_valid = 1'b0; long_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("rst_we", 64'(write_enable), 64'd0);
    check("rst_waddr", 64'(write_addr), 64'd0);
    check("rst_wdata", write_data, 64'd0);
    check("rst_count", 64'(fifo_count), 64'd0);
    check("rst_alu_ready", 64'(alu_ready), 64'd1);
    check("rst_long_ready", 64'(long_ready), 64'd1);
    model_clear();
    @(posedge clk);
    #2 rst = 1'b0;
  endtask

  initial begin
    logic        av, lv;
    logic [5:0]  aa, la;
    logic [63:0] ad, ld;

    model_clear();
    do_reset();

    // idle: no writes
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0);

    // ALU write then idle hold
    step(1, 6'd5, 64'hDEADBEEF, 0, 0, 0);
    check("alu_we", 64'(write_enable), 64'd1);
    check("alu_addr5", 64'(write_addr), 64'd5);
    step(0, 0, 0, 0, 0, 0);
    check("idle_hold_addr", 64'(write_addr), 64'd5);

    // addr-0 drop on both paths
    step(1, 6'd0, 64'h1234, 0, 0, 0);
    check("alu_addr0_we", 64'(write_enable), 64'd0);
    step(0, 0, 0, 1, 6'd0, 64'h55);
    step(0, 0, 0, 0, 0, 0);
    check("long_addr0_count", 64'(fifo_count), 64'd0);

    // fill with ALU busy, starvation, ordered drain
    for (int i = 0; i < 4; i++)
      step(1, 6'(10 + i), 64'(100 + i), 1, 6'(33 + i), 64'(64'hF000 + i));
    check("full_count", 64'(fifo_count), 64'd4);
    check("full_long_ready", 64'(long_ready), 64'd0);
    for (int i = 0; i < 40; i++)
      step(1, 6'(1 + (i % 20)), 64'(200 + i), 0, 0, 0);
    check("drained", 64'(fifo_count), 64'd0);

    // push and pop in the same cycle at count 2
    step(1, 6'd7, 64'h7, 1, 6'd40, 64'h40);
    step(1, 6'd8, 64'h8, 1, 6'd41, 64'h41);
    step(0, 0, 0, 1, 6'd42, 64'h42);
    check("pushpop_count", 64'(fifo_count), 64'd2);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 0);
    // push into empty FIFO: written one cycle later
    step(0, 0, 0, 1, 6'd50, 64'h50);
    check("no_bypass_we", 64'(write_enable), 64'd0);
    step(0, 0, 0, 0, 0, 0);
    check("late_write_addr", 64'(write_addr), 64'd50);

    // reset mid-operation with 3 entries buffered
    for (int i = 0; i < 3; i++) step(1, 6'd9, 64'h9, 1, 6'(20 + i), 64'(i));
    check("pre_rst_count", 64'(fifo_count), 64'd3);
    do_reset();
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 0);

    // randomized traffic honoring producer holds
    av = 0; lv = 0; aa = 0; la = 0; ad = 0; ld = 0;
    alu_taken = 1; long_taken = 1;
    for (int i = 0; i < 400; i++) begin
      if (!(av && !alu_taken)) begin
        av = ($urandom_range(0, 9) < 8);
        aa = 6'($urandom_range(0, 63));
        ad = {32'($urandom), 32'($urandom)};
      end
      if (!(lv && !long_taken)) begin
        lv = ($urandom_range(0, 9) < 5);
        la = 6'($urandom_range(0, 63));
        ld = {32'($urandom), 32'($urandom)};
      end
      step(av, aa, ad, lv, la, ld);
    end
    for (int i = 0; i < 12; i++) step(0, 0, 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
